// File: rtl/data_store_buffer.sv
// Posted-write store buffer between the MEM stage and the data RAM port.
// Stores queue in order and drain whenever the RAM port is granted and no load is using it.
// Loads own the port and see queued stores through byte-lane forwarding.
// Optional feature: define STORE_BUFFER_MERGE_EN to coalesce a store into the youngest
// entry when both target the same word.
module data_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_ce_i,
  input  logic          mem_we_i,
  input  logic [AW-1:0] mem_addr_i,
  input  logic [3:0]    mem_sel_i,
  input  logic [DW-1:0] mem_data_i,
  output logic [DW-1:0] mem_data_o,
  output logic          stall_req_o,
  output logic          sb_empty_o,
  input  logic          ram_gnt_i,
  output logic          ram_ce_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [3:0]    ram_sel_o,
  output logic [DW-1:0] ram_data_o,
  input  logic [DW-1:0] ram_data_i
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned BW = DW / 4;

  typedef logic [PW-1:0] ptr_t;

  logic [AW-1:0] addr_q [DEPTH];
  logic [3:0]    sel_q  [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  ptr_t          head_q, tail_q;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q;

  logic          is_load, is_store, full, drain, merge, enq;
  logic [DW-1:0] fwd_data;

  assign is_load  = mem_ce_i & ~mem_we_i;
  assign is_store = mem_ce_i & mem_we_i & (|mem_sel_i);
  assign full     = (count_q == CW'(DEPTH));
  // Loads own the port, so the queue only drains in cycles without a load.
  assign drain    = ~rst & ~is_load & ram_gnt_i & (count_q != '0);

`ifdef STORE_BUFFER_MERGE_EN
  ptr_t youngest;
  assign youngest = tail_q - 1'b1;
  // A sole entry that is leaving this cycle cannot absorb the store.
  assign merge = is_store & (count_q != '0)
               & (addr_q[youngest][AW-1:2] == mem_addr_i[AW-1:2])
               & ~(drain & (count_q == CW'(1)));
`else
  assign merge = 1'b0;
`endif

  // A full queue still accepts a store when the head leaves at the same edge.
  assign enq     = is_store & ~merge & (~full | drain);
  assign count_d = count_q + CW'(enq) - CW'(drain);

  assign stall_req_o = ~rst & ((is_load & ~ram_gnt_i) | (is_store & ~merge & full & ~drain));
  assign sb_empty_o  = empty_q;

  // Overlay queued bytes on RAM read data, oldest first so the youngest store wins.
  always_comb begin
    ptr_t idx;
    fwd_data = ram_data_i;
    idx      = head_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx][AW-1:2] == mem_addr_i[AW-1:2])) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (sel_q[idx][b]) fwd_data[BW*b +: BW] = data_q[idx][BW*b +: BW];
        end
      end
    end
  end

  assign mem_data_o = (~rst & is_load & ram_gnt_i) ? fwd_data : '0;

  // RAM port: a granted load has priority, otherwise the head entry drains.
  always_comb begin
    ram_ce_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_sel_o  = '0;
    ram_data_o = '0;
    if (!rst) begin
      if (is_load && ram_gnt_i) begin
        ram_ce_o   = 1'b1;
        ram_addr_o = mem_addr_i;
        ram_sel_o  = mem_sel_i;
      end else if (drain) begin
        ram_ce_o   = 1'b1;
        ram_we_o   = 1'b1;
        ram_addr_o = addr_q[head_q];
        ram_sel_o  = sel_q[head_q];
        ram_data_o = data_q[head_q];
      end
    end
  end

  // Pointer, occupancy and registered empty flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
    end else begin
      if (drain) head_q <= head_q + 1'b1;
      if (enq)   tail_q <= tail_q + 1'b1;
      count_q <= count_d;
      empty_q <= (count_d == '0);
    end
  end

  // Entry storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      addr_q[tail_q] <= mem_addr_i;
      sel_q[tail_q]  <= mem_sel_i;
      data_q[tail_q] <= mem_data_i;
    end
`ifdef STORE_BUFFER_MERGE_EN
    if (!rst && merge) begin
      sel_q[youngest] <= sel_q[youngest] | mem_sel_i;
      for (int unsigned b = 0; b < 4; b++) begin
        if (mem_sel_i[b]) data_q[youngest][BW*b +: BW] <= mem_data_i[BW*b +: BW];
      end
    end
`endif
  end

endmodule
